// File: rtl/demux_stream.sv
// Single-slot registered 1:N stream demultiplexer.
// Optional packet mode locks the destination from first beat to in_last.
module demux_stream #(
  parameter int WIDTH  = 8,
  parameter int SELW   = 2,
  parameter bit STICKY = 1'b0,
  localparam int N     = 2**SELW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [SELW-1:0]      s,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   y,
  output logic [N-1:0]         y_valid,
  output logic [N-1:0]         y_last,
  input  logic [N-1:0]         y_ready,
  output logic                 busy
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t           state_q;
  logic [SELW-1:0]  lock_q;
  logic             full_q, full_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  logic             accept;
  logic             drain;
  logic [SELW-1:0]  dest;

  assign in_ready = !full_q || y_ready[ch_q];
  assign accept   = in_valid && in_ready;
  assign drain    = full_q && y_ready[ch_q];
  assign busy     = STICKY && (state_q == PKT);

  // Once a packet is open, s is ignored until its last beat.
  assign dest = (STICKY && state_q == PKT) ? lock_q : s;

  always_comb begin
    full_d = full_q;
    ch_d   = ch_q;
    data_d = data_q;
    last_d = last_q;
    if (accept) begin
      full_d = 1'b1;
      ch_d   = dest;
      data_d = a;
      last_d = in_last;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      ch_q   <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      full_q <= full_d;
      ch_q   <= ch_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else if (STICKY && accept) begin
      case (state_q)
        IDLE: begin
          lock_q <= s;
          if (!in_last) state_q <= PKT;
        end
        PKT: begin
          if (in_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    y       = '0;
    y_valid = '0;
    y_last  = '0;
    for (int k = 0; k < N; k++) begin
      if (full_q && ch_q == SELW'(k)) begin
        y[k*WIDTH +: WIDTH] = data_q;
        y_valid[k]          = 1'b1;
        y_last[k]           = last_q;
      end
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed scenarios on both modes,
// then random traffic against a per-channel queue model.
module tb_demux_stream;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][7:0]  a;
  logic [1:0][1:0]  s;
  logic [1:0]       iv, il;
  logic [1:0][3:0]  yr;
  wire  [1:0]       ir, bz;
  wire  [1:0][3:0]  yv, yl;
  wire  [1:0][31:0] y;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_stream #(.WIDTH(8), .SELW(2), .STICKY(1'b0)) u0 (
    .clk(clk), .rst(rst), .a(a[0]), .s(s[0]),
    .in_valid(iv[0]), .in_last(il[0]), .in_ready(ir[0]),
    .y(y[0]), .y_valid(yv[0]), .y_last(yl[0]),
    .y_ready(yr[0]), .busy(bz[0])
  );

  demux_stream #(.WIDTH(8), .SELW(2), .STICKY(1'b1)) u1 (
    .clk(clk), .rst(rst), .a(a[1]), .s(s[1]),
    .in_valid(iv[1]), .in_last(il[1]), .in_ready(ir[1]),
    .y(y[1]), .y_valid(yv[1]), .y_last(yl[1]),
    .y_ready(yr[1]), .busy(bz[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [7:0] d, input int k);
    return 32'(d) << (k*8);
  endfunction

  // Reference: one slot of buffering, a packet lock, and per-channel queues
  bit          mfull, mlast, mopen;
  logic [1:0]  mch, mlock;
  logic [7:0]  mdata;
  logic [8:0]  expq [4][$];

  task automatic rnd_cycle(input int m, input bit idle);
    bit         rdy, acc;
    logic [1:0] dest;
    logic [8:0] e;
    @(negedge clk);
    chk("r_valid", 32'(yv[m]), mfull ? 32'(1 << mch) : 32'd0);
    chk("r_data", y[m], mfull ? lane(mdata, int'(mch)) : 32'd0);
    chk("r_last", 32'(yl[m]), (mfull && mlast) ? 32'(1 << mch) : 32'd0);
    chk("r_busy", 32'(bz[m]), 32'((m == 1) && mopen));
    chk("r_onehot", 32'($countones(yv[m]) <= 1), 32'd1);
    if (idle) begin
      iv[m] = 1'b0;
      il[m] = 1'b0;
      yr[m] = 4'hF;
    end else begin
      iv[m] = ($urandom % 4) != 0;
      a[m]  = 8'($urandom);
      s[m]  = 2'($urandom);
      il[m] = ($urandom % 3) == 0;
      yr[m] = 4'($urandom_range(0, 15));
    end
    #1;
    rdy = !mfull || yr[m][mch];
    chk("r_ready", 32'(ir[m]), 32'(rdy));
    for (int k = 0; k < 4; k++) begin
      if (yv[m][k] && yr[m][k]) begin
        if (expq[k].size() == 0) begin
          chk("r_extra", 32'(yv[m][k]), 32'd0);
        end else begin
          e = expq[k].pop_front();
          chk("r_sb", 32'({yl[m][k], y[m][k*8 +: 8]}), 32'(e));
        end
      end
    end
    acc  = iv[m] && rdy;
    dest = (m == 1 && mopen) ? mlock : s[m];
    if (acc) begin
      expq[dest].push_back({il[m], a[m]});
      mfull = 1'b1;
      mch   = dest;
      mdata = a[m];
      mlast = il[m];
      if (m == 1) begin
        if (!mopen) begin
          mlock = s[m];
          mopen = !il[m];
        end else if (il[m]) begin
          mopen = 1'b0;
        end
      end
    end else if (mfull && yr[m][mch]) begin
      mfull = 1'b0;
    end
  endtask

  task automatic rnd_phase(input int m, input int cycles);
    @(negedge clk);
    iv = '0; il = '0; yr = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mfull = 0; mlast = 0; mopen = 0;
    mch = '0; mlock = '0; mdata = '0;
    for (int k = 0; k < 4; k++) expq[k].delete();
    for (int c = 0; c < cycles + 4; c++) rnd_cycle(m, c >= cycles);
    for (int k = 0; k < 4; k++) chk("r_left", 32'(expq[k].size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a = '0; s = '0; iv = '0; il = '0; yr = '0;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_y", y[m], 32'd0);
      chk("rst_valid", 32'(yv[m]), 32'd0);
      chk("rst_last", 32'(yl[m]), 32'd0);
      chk("rst_busy", 32'(bz[m]), 32'd0);
      chk("rst_ready", 32'(ir[m]), 32'd1);
    end
    rst = 1'b0;

    // Per-beat routing at full rate
    yr[0] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("t_seq_valid", 32'(yv[0]), 32'(1 << (i-1)));
        chk("t_seq_data", y[0], lane(8'(i * 8'h11), i-1));
      end
      if (i < 4) begin
        iv[0] = 1'b1;
        a[0]  = 8'((i+1) * 8'h11);
        s[0]  = 2'(i);
      end else begin
        iv[0] = 1'b0;
      end
      #1 chk("t_seq_ready", 32'(ir[0]), 32'd1);
    end

    // Backpressure on lane 2, then no-bubble handover
    @(negedge clk);
    iv[0] = 1'b1; a[0] = 8'hA5; s[0] = 2'd2; yr[0] = 4'hB;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t_bp_valid", 32'(yv[0]), 32'h4);
      chk("t_bp_data", y[0], lane(8'hA5, 2));
      a[0] = 8'h5A; s[0] = 2'd0;
      if (j == 3) yr[0] = 4'hF;
      #1 chk("t_bp_ready", 32'(ir[0]), (j == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t_bp_next_valid", 32'(yv[0]), 32'h1);
    chk("t_bp_next_data", y[0], lane(8'h5A, 0));
    iv[0] = 1'b0;
    @(negedge clk);
    chk("t_bp_empty", 32'(yv[0]), 32'd0);

    // Three-beat packet locked to lane 3
    yr[1] = 4'hF;
    @(negedge clk);
    iv[1] = 1'b1; a[1] = 8'h01; s[1] = 2'd3; il[1] = 1'b0;
    #1 chk("t_pkt_busy0", 32'(bz[1]), 32'd0);
    @(negedge clk);
    chk("t_pkt_v1", 32'(yv[1]), 32'h8);
    chk("t_pkt_d1", y[1], lane(8'h01, 3));
    chk("t_pkt_l1", 32'(yl[1]), 32'd0);
    chk("t_pkt_busy1", 32'(bz[1]), 32'd1);
    a[1] = 8'h02; s[1] = 2'd0;
    @(negedge clk);
    chk("t_pkt_v2", 32'(yv[1]), 32'h8);
    chk("t_pkt_d2", y[1], lane(8'h02, 3));
    chk("t_pkt_busy2", 32'(bz[1]), 32'd1);
    a[1] = 8'h03; s[1] = 2'd1; il[1] = 1'b1;
    @(negedge clk);
    chk("t_pkt_v3", 32'(yv[1]), 32'h8);
    chk("t_pkt_d3", y[1], lane(8'h03, 3));
    chk("t_pkt_l3", 32'(yl[1]), 32'h8);
    chk("t_pkt_busy3", 32'(bz[1]), 32'd0);
    iv[1] = 1'b0; il[1] = 1'b0;

    // Single-beat packet
    @(negedge clk);
    iv[1] = 1'b1; a[1] = 8'h7E; s[1] = 2'd1; il[1] = 1'b1;
    #1 chk("t_one_busy0", 32'(bz[1]), 32'd0);
    @(negedge clk);
    chk("t_one_valid", 32'(yv[1]), 32'h2);
    chk("t_one_data", y[1], lane(8'h7E, 1));
    chk("t_one_last", 32'(yl[1]), 32'h2);
    chk("t_one_busy1", 32'(bz[1]), 32'd0);
    iv[1] = 1'b0; il[1] = 1'b0;

    // Reset mid-packet with a held beat
    @(negedge clk);
    iv[1] = 1'b1; a[1] = 8'h9C; s[1] = 2'd3; yr[1] = 4'h0;
    @(negedge clk);
    chk("t_rst_held", 32'(yv[1]), 32'h8);
    chk("t_rst_busy_pre", 32'(bz[1]), 32'd1);
    iv[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t_rst_valid", 32'(yv[1]), 32'd0);
    chk("t_rst_busy", 32'(bz[1]), 32'd0);
    chk("t_rst_y", y[1], 32'd0);
    chk("t_rst_ready", 32'(ir[1]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    yr[1] = 4'hF;
    iv[1] = 1'b1; a[1] = 8'hC3; s[1] = 2'd2; il[1] = 1'b0;
    @(negedge clk);
    chk("t_rst_after_v", 32'(yv[1]), 32'h4);
    chk("t_rst_after_d", y[1], lane(8'hC3, 2));
    chk("t_rst_after_busy", 32'(bz[1]), 32'd1);
    iv[1] = 1'b0;

    rnd_phase(0, 1500);
    rnd_phase(1, 1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
